// File: rtl/if_pc_stage.sv
// if_pc_stage -- instruction-fetch stage: program counter register plus the
// IF/ID pipeline register.
//
// Optional build macro: PC_ALIGN_CHECK_EN
//   defined   : a fetch from a misaligned address or from outside
//               [IM_LO, IM_HI] is flagged on if_id_adr_err. The IF/ID
//               register then holds a nop (32'h0) with valid=1, and the PC
//               keeps following npc.
//   undefined : no address checking. if_id_adr_err is tied low, and the
//               fetched word is captured whatever the PC value.
//
// Pipeline control inputs:
//   The hazard unit drives stall and flush level-sensitively, once per cycle,
//   and there is no acknowledge. Priority at each rising edge is
//   reset > stall > flush > normal advance.
//   - stall holds the PC and every IF/ID register and ignores npc. A flush
//     requested in the same cycle is dropped, not deferred.
//   - flush loads npc into the PC and writes a bubble (all zero, valid=0)
//     into IF/ID.

module if_pc_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] IM_LO    = 32'h0000_3000,
  parameter logic [31:0] IM_HI    = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] npc,
  input  logic [31:0] instr,
  input  logic        stall,
  input  logic        flush,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc8,
  output logic        if_id_valid,
  output logic        if_id_adr_err
);

  logic [31:0] r_pc;
  logic [31:0] r_if_id_instr;
  logic [31:0] r_if_id_pc;
  logic [31:0] r_if_id_pc8;
  logic        r_if_id_valid;
  logic        r_if_id_adr_err;

  logic [31:0] w_pc4;
  logic [31:0] w_pc8;
  logic        w_adr_err;
  logic [31:0] w_fetch_instr;

  // Link and sequential addresses wrap modulo 2^32; any carry is discarded.
  assign w_pc4 = r_pc + 32'd4;
  assign w_pc8 = r_pc + 32'd8;

`ifdef PC_ALIGN_CHECK_EN
  // Flag a fetch that is misaligned or outside instruction memory. The word
  // returned for such an address is meaningless, so a nop is captured instead.
  assign w_adr_err     = (r_pc[1:0] != 2'b00) || (r_pc < IM_LO) || (r_pc > IM_HI);
  assign w_fetch_instr = w_adr_err ? 32'h0000_0000 : instr;
`else
  // No address checking: always take the memory word.
  assign w_adr_err     = 1'b0;
  assign w_fetch_instr = instr;
`endif

  // A mis-parameterised instance with an empty or misaligned fetch window
  // would flag every fetch. Catch it early.
  a_param_window: assert property (@(posedge clk)
    (IM_LO <= IM_HI) && (IM_LO[1:0] == 2'b00) && (IM_HI[1:0] == 2'b00));

  // Program counter: reset vector, hold on stall, otherwise follow npc unmodified.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else if (!stall) begin
      r_pc <= npc;
    end
  end

  // IF/ID register: clear on reset, hold on stall, bubble on flush, else capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_if_id_instr   <= 32'h0000_0000;
      r_if_id_pc      <= 32'h0000_0000;
      r_if_id_pc8     <= 32'h0000_0000;
      r_if_id_valid   <= 1'b0;
      r_if_id_adr_err <= 1'b0;
    end else if (!stall) begin
      if (flush) begin
        r_if_id_instr   <= 32'h0000_0000;
        r_if_id_pc      <= 32'h0000_0000;
        r_if_id_pc8     <= 32'h0000_0000;
        r_if_id_valid   <= 1'b0;
        r_if_id_adr_err <= 1'b0;
      end else begin
        r_if_id_instr   <= w_fetch_instr;
        r_if_id_pc      <= r_pc;
        r_if_id_pc8     <= w_pc8;
        r_if_id_valid   <= 1'b1;
        r_if_id_adr_err <= w_adr_err;
      end
    end
  end

  // The PC output comes only from the register, so there is no npc-to-pc path.
  assign pc            = r_pc;
  assign pc4           = w_pc4;
  assign if_id_instr   = r_if_id_instr;
  assign if_id_pc      = r_if_id_pc;
  assign if_id_pc8     = r_if_id_pc8;
  assign if_id_valid   = r_if_id_valid;
  assign if_id_adr_err = r_if_id_adr_err;

endmodule
